// File: rtl/ps2_pkg.sv
// ps2_pkg: frame states and keyboard prefix codes shared by the PS/2 receiver.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 lines, deframes 11-bit frames and flags good bytes and errors.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       good,
  output logic       bad_parity,
  output logic       bad_frame,
  output logic       timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  frame_state_t state, state_n;
  logic [2:0] clk_q;
  logic [1:0] data_q;
  logic [2:0] bit_cnt;
  logic acc, parity_ok;
  logic [TW-1:0] tcnt;
  logic fall, sample;
  assign fall = clk_q[2] & ~clk_q[1];
  assign sample = data_q[1];
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      clk_q <= '1;
      data_q <= '1;
      state <= IDLE;
    end else begin
      clk_q <= {clk_q[1:0], ps2_clk};
      data_q <= {data_q[0], ps2_data};
      state <= state_n;
    end
  always_comb begin
    state_n = state;
    good = 1'b0;
    bad_parity = 1'b0;
    bad_frame = 1'b0;
    timeout = 1'b0;
    if (fall)
      case (state)
        IDLE:    state_n = sample ? IDLE : DATA;
        DATA:    state_n = (bit_cnt == 3'd7) ? PARITY : DATA;
        PARITY:  state_n = STOP;
        default: begin
          state_n = IDLE;
          good = sample & parity_ok;
          bad_frame = ~sample;
          bad_parity = sample & ~parity_ok;
        end
      endcase
    else if (state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
      state_n = IDLE;
      timeout = 1'b1;
    end
  end
  // Shift register, parity accumulator and inactivity counter.
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      byte_data <= '0;
      bit_cnt <= '0;
      acc <= 1'b0;
      parity_ok <= 1'b0;
      tcnt <= '0;
    end else begin
      tcnt <= (fall || state == IDLE || timeout) ? '0 : tcnt + 1'b1;
      if (fall && state == IDLE) begin
        bit_cnt <= '0;
        acc <= 1'b0;
      end
      if (fall && state == DATA) begin
        byte_data <= {sample, byte_data[7:1]};
        acc <= acc ^ sample;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (fall && state == PARITY) parity_ok <= acc ^ sample;
    end
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 host receiver with raw byte output and E0/F0 prefix decoding onto a valid/ready event port.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT    = 4096,
  parameter bit KBD_DECODE = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] raw_data,
  output logic       raw_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_overrun,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout
);
  logic [7:0] byte_data;
  logic good, bad_parity, bad_frame, timeout;
  logic ext, brk, is_ext, is_brk, is_pfx, err, new_ev, hs, load;
  ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_frame (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (byte_data),
    .good      (good),
    .bad_parity(bad_parity),
    .bad_frame (bad_frame),
    .timeout   (timeout)
  );
  assign is_ext = KBD_DECODE && byte_data == PS2_EXT;
  assign is_brk = KBD_DECODE && byte_data == PS2_BRK;
  assign is_pfx = is_ext | is_brk;
  assign err = bad_parity | bad_frame | timeout;
  assign new_ev = good & ~is_pfx;
  assign hs = ev_valid & ev_ready;
  // A new event may replace the held one only when it is being consumed this cycle.
  assign load = new_ev & (~ev_valid | hs);
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      raw_data <= '0;
      raw_valid <= 1'b0;
      err_parity <= 1'b0;
      err_frame <= 1'b0;
      err_timeout <= 1'b0;
      ext <= 1'b0;
      brk <= 1'b0;
      ev_code <= '0;
      ev_ext <= 1'b0;
      ev_brk <= 1'b0;
      ev_valid <= 1'b0;
      ev_overrun <= 1'b0;
    end else begin
      raw_valid <= good;
      err_parity <= bad_parity;
      err_frame <= bad_frame;
      err_timeout <= timeout;
      if (good) raw_data <= byte_data;
      ext <= err ? 1'b0 : good ? (is_pfx ? ext | is_ext : 1'b0) : ext;
      brk <= err ? 1'b0 : good ? (is_pfx ? brk | is_brk : 1'b0) : brk;
      if (load) begin
        ev_code <= byte_data;
        ev_ext <= ext;
        ev_brk <= brk;
      end
      ev_valid <= load | (ev_valid & ~ev_ready);
      ev_overrun <= hs ? 1'b0 : ev_overrun | (new_ev & ev_valid);
    end
endmodule
